// File: rtl/program_loader_if.sv
// Byte-stream handshake between the host-side source and program_loader.
// The source drives in_valid/in_data; the loader answers with in_ready.
interface program_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Frame-to-write-strobe loader for the Salamander-4 instruction memory; holds the core in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// HEADER | waiting for word count byte N
// DATA   | receiving N payload bytes, one write per byte
// CHECK  | waiting for XOR checksum byte (checksum build only)
// DONE   | program loaded, core released
// ERROR  | frame rejected, core held in reset
module program_loader #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  program_loader_if.slave      s_in,
  output logic                 W,
  output logic [DATA_SIZE-1:0] DATA_WR,
  output logic [ADDR_SIZE-1:0] ADDR,
  output logic                 cpu_rstn,
  output logic                 done,
  output logic                 error
);

  localparam int CAP = 2**ADDR_SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t               r_state;
  logic [8:0]           r_count;
  logic [ADDR_SIZE-1:0] r_addr;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]           r_csum;
`endif

  logic w_accept;
  logic w_hdr_ok;
  logic w_word_ok;

  always_comb begin
    s_in.in_ready = 1'b0;
    case (r_state)
      S_HEADER, S_DATA: s_in.in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK:          s_in.in_ready = 1'b1;
`endif
      default:          s_in.in_ready = 1'b0;
    endcase
  end

  assign w_accept  = s_in.in_valid & s_in.in_ready;
  assign w_hdr_ok  = (s_in.in_data != 8'd0) && ({1'b0, s_in.in_data} <= 9'(CAP));
  assign w_word_ok = (s_in.in_data >> DATA_SIZE) == 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_addr   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_csum   <= '0;
`endif
      W        <= 1'b0;
      DATA_WR  <= '0;
      ADDR     <= '0;
      cpu_rstn <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      W <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state  <= S_HEADER;
            r_count  <= '0;
            r_addr   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_csum   <= '0;
`endif
            cpu_rstn <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        S_HEADER: begin
          if (w_accept) begin
            if (w_hdr_ok) begin
              r_state <= S_DATA;
              r_count <= {1'b0, s_in.in_data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              r_csum  <= r_csum ^ s_in.in_data;
`endif
            end else begin
              r_state <= S_ERROR;
              error   <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            if (!w_word_ok) begin
              r_state <= S_ERROR;
              error   <= 1'b1;
            end else begin
              W       <= 1'b1;
              DATA_WR <= s_in.in_data[DATA_SIZE-1:0];
              ADDR    <= r_addr;
              r_addr  <= r_addr + 1'b1;
              r_count <= r_count - 9'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              r_csum  <= r_csum ^ s_in.in_data;
              if (r_count == 9'd1) r_state <= S_CHECK;
`else
              if (r_count == 9'd1) begin
                r_state  <= S_DONE;
                done     <= 1'b1;
                cpu_rstn <= 1'b1;
              end
`endif
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            if (s_in.in_data == r_csum) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              cpu_rstn <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              error   <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes queued at stimulus time, popped on each W.
// Checksum frames follow PROGRAM_LOADER_CHECKSUM_EN as the RTL does.
module tb_program_loader;
  localparam int DS = 6;
  localparam int AS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          W;
  logic [DS-1:0] DATA_WR;
  logic [AS-1:0] ADDR;
  logic          cpu_rstn;
  logic          done;
  logic          error;

  program_loader_if bus();

  program_loader #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) dut (
    .clk(clk), .rst(rst), .start(start), .s_in(bus),
    .W(W), .DATA_WR(DATA_WR), .ADDR(ADDR),
    .cpu_rstn(cpu_rstn), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AS+DS-1:0] exp_q[$];
  bit gap_watch = 1'b0;

  // write monitor: every W must match the head of the expected queue
  always @(negedge clk) begin
    logic [AS+DS-1:0] e;
    if (W === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write ADDR=%0h DATA_WR=%0h required=no write", ADDR, DATA_WR);
      end else begin
        e = exp_q.pop_front();
        if ({ADDR, DATA_WR} !== e) begin
          errors++;
          $display("FAIL write ADDR=%0h DATA_WR=%0h required ADDR=%0h DATA_WR=%0h",
                   ADDR, DATA_WR, e[AS+DS-1:DS], e[DS-1:0]);
        end
      end
    end
    if (gap_watch) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL gap_in_ready got=%b required=1", bus.in_ready);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input int a, input int d);
    logic [AS-1:0] av;
    logic [DS-1:0] dv;
    av = a[AS-1:0];
    dv = d[DS-1:0];
    exp_q.push_back({av, dv});
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input bit watch);
    bit acc;
    int n;
    bus.in_valid = 1'b0;
    gap_watch = watch;
    repeat (gap) tick();
    gap_watch = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      n++;
      if (!acc && n > 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout byte=%0h in_ready=0 required=1", b);
        acc = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || cpu_rstn !== 1'b0) begin
      errors++;
      $display("FAIL start_header in_ready=%b done=%b error=%b cpu_rstn=%b required 1,0,0,0",
               bus.in_ready, done, error, cpu_rstn);
    end
    tick();
  endtask

  task automatic check_end(input string name, input bit d, input bit e);
    @(negedge clk);
    checks++;
    if (done !== d || error !== e || cpu_rstn !== d || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_status done=%b error=%b cpu_rstn=%b in_ready=%b required done=%b error=%b cpu_rstn=%b in_ready=0",
               name, done, error, cpu_rstn, bus.in_ready, d, e, d);
    end
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes got=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || W !== 1'b0 || DATA_WR !== '0 || ADDR !== '0 ||
        cpu_rstn !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready=%b W=%b DATA_WR=%0h ADDR=%0h cpu_rstn=%b done=%b error=%b required all 0",
               name, bus.in_ready, W, DATA_WR, ADDR, cpu_rstn, done, error);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset_values");
    rst = 1'b0;
    tick();
    check_reset_outputs("idle_after_reset");
    tick();
  endtask

  task automatic test_basic(input int gap);
    pulse_start();
    push(0, 'h05); push(1, 'h2A); push(2, 'h11);
    send_byte(8'h03, gap, gap > 0);
    send_byte(8'h05, gap, gap > 0);
    send_byte(8'h2A, gap, gap > 0);
    send_byte(8'h11, gap, gap > 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h3D, gap, gap > 0);
`endif
    check_end(gap > 0 ? "gaps" : "back_to_back", 1'b1, 1'b0);
  endtask

  task automatic test_bad_header(input logic [7:0] h);
    pulse_start();
    send_byte(h, 0, 1'b0);
    check_end("bad_header", 1'b0, 1'b1);
  endtask

  task automatic test_bad_payload();
    pulse_start();
    push(0, 'h07);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h07, 0, 1'b0);
    send_byte(8'hC1, 0, 1'b0);
    check_end("bad_payload", 1'b0, 1'b1);
  endtask

  task automatic test_checksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    pulse_start();
    push(0, 'h01); push(1, 'h02);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    check_end("checksum_bad", 1'b0, 1'b1);
    pulse_start();
    push(0, 'h01); push(1, 'h02);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    check_end("checksum_good", 1'b1, 1'b0);
`endif
  endtask

  task automatic test_full_capacity();
    logic [7:0] cs;
    logic [7:0] d;
    pulse_start();
    cs = 8'h20;
    send_byte(8'h20, 0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      d = 8'((i * 5 + 3) % 64);
      push(i, d);
      cs = cs ^ d;
      send_byte(d, 0, 1'b0);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(cs, 0, 1'b0);
`endif
    check_end("full_capacity", 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    pulse_start();
    push(0, 'h01); push(1, 'h02);
    send_byte(8'h02, 0, 1'b0);
    start = 1'b1;
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    start = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h01, 0, 1'b0);
`endif
    check_end("start_ignored", 1'b1, 1'b0);
  endtask

  task automatic test_rst_mid_load();
    pulse_start();
    push(0, 'h0A); push(1, 'h0B);
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h0A, 0, 1'b0);
    send_byte(8'h0B, 0, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid_load");
    rst = 1'b0;
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_pending got=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    pulse_start();
    push(0, 'h15); push(1, 'h16);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h15, 0, 1'b0);
    send_byte(8'h16, 0, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h01, 0, 1'b0);
`endif
    check_end("reload_after_rst", 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic(0);
    test_basic(2);
    test_bad_header(8'h00);
    test_bad_header(8'h21);
    test_bad_payload();
    test_checksum();
    test_full_capacity();
    test_start_ignored();
    test_rst_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder for the Salamander-4 core's instruction memory. It accepts a framed byte stream over a valid/ready handshake and converts it into single-cycle write strobes on the core's `W`/`DATA_WR`/`ADDR` load port. It holds the core in reset while loading and releases it once a complete, well-formed program is in memory. It sits between the host-side byte source (UART receiver or bench) and `top_level`.

## Interface
Parameters:
- `DATA_SIZE`, 6: instruction width; low bits of each payload byte.
- `ADDR_SIZE`, 5: instruction memory address width; capacity `2**ADDR_SIZE` words.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled in IDLE, DONE, ERROR only.
- `in_valid`  in  1  byte source has data.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts byte this cycle.
- `W`  out  1  instruction memory write strobe, one cycle per word.
- `DATA_WR`  out  DATA_SIZE  instruction word to write.
- `ADDR`  out  ADDR_SIZE  write address.
- `cpu_rstn`  out  1  core reset, active-low; low holds core in reset.
- `done`  out  1  program loaded and core released.
- `error`  out  1  frame rejected.

## Operation
- Frame: header byte N (word count), then N payload bytes, then (checksum build only) one checksum byte.
- Byte accepted on any cycle with `in_valid && in_ready`; `in_ready` is combinational from state: 1 in HEADER, DATA, CHECK; 0 elsewhere.
- States: IDLE, HEADER, DATA, CHECK, DONE, ERROR.
  - IDLE/DONE/ERROR + `start` -> HEADER; clears `done`, `error`, word counter, write address, checksum; drives `cpu_rstn`=0.
  - HEADER: accepted N with 1 <= N <= `2**ADDR_SIZE` -> DATA, counter = N. N=0 or N > `2**ADDR_SIZE` -> ERROR.
  - DATA: each accepted byte: if `in_data[7:DATA_SIZE]` != 0 -> ERROR, no write for that byte. Otherwise schedules a write of `in_data[DATA_SIZE-1:0]` at current address, address +1, counter -1. Last word -> CHECK (checksum build) or DONE.
  - CHECK: accepted byte equal to running XOR -> DONE, else -> ERROR.
  - DONE: `done`=1, `cpu_rstn`=1. ERROR: `error`=1, `cpu_rstn`=0. Both hold until `start`.
- Write address starts at 0 every load, wraps mod `2**ADDR_SIZE` (only reachable at N = `2**ADDR_SIZE`, after last write).
- Running checksum: 8-bit XOR of header and all payload bytes as received.
- `start` in HEADER/DATA/CHECK is ignored.
- Words already written before an ERROR stay in memory; core remains in reset.

## Timing
- Reset values: `in_ready`=0, `W`=0, `DATA_WR`=0, `ADDR`=0, `cpu_rstn`=0, `done`=0, `error`=0, state IDLE.
- `rst` mid-load: next cycle back to IDLE with all reset values; pending write dropped.
- `W`, `DATA_WR`, `ADDR` registered: payload byte accepted at edge k -> `W`=1 with word/address during cycle k+1, `W`=0 afterwards unless another byte accepted at k+1. Back-to-back bytes give back-to-back writes, max throughput 1 word/cycle.
- `DATA_WR`/`ADDR` hold last written values when `W`=0.
- Transition to DONE occurs on the edge accepting the final byte; `done`/`cpu_rstn` rise in the same cycle as the final `W` (no-checksum build) or the cycle after the checksum byte is accepted (checksum build).
- `start` -> HEADER with `in_ready`=1 on the next cycle.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined: CHECK state and checksum register present; frame carries a trailing XOR byte; mismatch -> ERROR.
- Undefined: no CHECK state, no checksum logic; DATA goes directly to DONE after word N; frame is header + payload only.

## Test plan
- Reset then `start`, stream 03,05,2A,11 (+ checksum 3D if enabled) back-to-back -> W pulses at ADDR 0,1,2 with DATA_WR 05,2A,11; `done`=1, `cpu_rstn`=1, `error`=0.
- Same frame with `in_valid` gaps of 2 cycles between bytes -> identical writes, no W without an accepted byte, `in_ready` steady 1.
- Header 00, and separately header 21 (ADDR_SIZE=5) -> ERROR, no W, `cpu_rstn`=0, `error`=1.
- Header 02, payload 07, C1 -> one write (ADDR 0, DATA_WR 07), then ERROR on C1; no write at ADDR 1.
- Checksum build: 02,01,02 then checksum 00 (expected 01) -> two writes, then `error`=1; rerun with 01 -> `done`=1.
- Assert `rst` one cycle after second payload byte of an N=4 load -> next cycle all outputs at reset values, state IDLE; subsequent `start` reloads from ADDR 0.
